// File: rtl/captura_operandos_if.sv
// Keypad-to-operand bus: upstream key handshake, downstream operand-pair
// handshake and the live display signals.
interface captura_operandos_if #(
  parameter int MAX_DIGITS = 3,
  parameter int DATA_W     = 10
);
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  logic               pressed_valid;
  logic signed [31:0] numero;
  logic               tecla_rst;
  logic               tecla_guardar;
  logic               ack_read;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic               ops_valid;
  logic               ops_ready;
  logic [DATA_W-1:0]  valor_actual;
  logic [DIG_W-1:0]   digitos;
  logic               operando_sel;

  modport master (
    output pressed_valid, numero, tecla_rst, tecla_guardar, ops_ready,
    input  ack_read, op_a, op_b, ops_valid, valor_actual, digitos, operando_sel
  );

  modport slave (
    input  pressed_valid, numero, tecla_rst, tecla_guardar, ops_ready,
    output ack_read, op_a, op_b, ops_valid, valor_actual, digitos, operando_sel
  );
endinterface

// File: rtl/system_captura_operandos.sv
// Builds two decimal operands from keypad keys, one key per press, and offers
// the completed pair downstream with a valid/ready handshake.
module system_captura_operandos #(
  parameter int MAX_DIGITS = 3,
  parameter int DATA_W     = 10
) (
  input  logic                clk,
  input  logic                rst,
  captura_operandos_if.slave  bus
);
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] CAPTURA       = 2'd0;
  localparam logic [1:0] ACK           = 2'd1;
  localparam logic [1:0] ESPERA_SOLTAR = 2'd2;
  localparam logic [1:0] ENVIO         = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] valor_q, valor_d;
  logic [DIG_W-1:0]  dig_q, dig_d;
  logic              sel_q, sel_d;
  logic              send_q, send_d;
  logic              is_digit;

  // Decimal shift-in computed with four guard bits, then truncated back.
  function automatic logic [DATA_W-1:0] shift_in_digit(
    input logic [DATA_W-1:0] v,
    input logic [3:0]        d
  );
    logic [DATA_W+3:0] w;
    w = {4'b0000, v} * (DATA_W + 4)'(10) + {{DATA_W{1'b0}}, d};
    return w[DATA_W-1:0];
  endfunction

  assign is_digit = !bus.numero[31] && (bus.numero <= 32'sd9);

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    valor_d = valor_q;
    dig_d   = dig_q;
    sel_d   = sel_q;
    send_d  = send_q;
    case (state_q)
      CAPTURA: begin
        if (bus.pressed_valid) begin
          state_d = ACK;
          if (bus.tecla_rst) begin
            op_a_d  = '0;
            op_b_d  = '0;
            valor_d = '0;
            dig_d   = '0;
            sel_d   = 1'b0;
            send_d  = 1'b0;
          end else if (bus.tecla_guardar) begin
            if (!sel_q) begin
              op_a_d = valor_q;
              sel_d  = 1'b1;
            end else begin
              op_b_d = valor_q;
              send_d = 1'b1;
            end
            valor_d = '0;
            dig_d   = '0;
          end else if (is_digit && (dig_q < DIG_W'(MAX_DIGITS))) begin
            valor_d = shift_in_digit(valor_q, bus.numero[3:0]);
            dig_d   = dig_q + DIG_W'(1);
          end
        end
      end
      ACK: state_d = ESPERA_SOLTAR;
      ESPERA_SOLTAR: begin
        // A completed pair is only offered once the store key is released.
        if (!bus.pressed_valid) state_d = send_q ? ENVIO : CAPTURA;
      end
      ENVIO: begin
        if (bus.ops_ready) begin
          state_d = CAPTURA;
          sel_d   = 1'b0;
          send_d  = 1'b0;
        end
      end
      default: state_d = CAPTURA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CAPTURA;
      op_a_q  <= '0;
      op_b_q  <= '0;
      valor_q <= '0;
      dig_q   <= '0;
      sel_q   <= 1'b0;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      valor_q <= valor_d;
      dig_q   <= dig_d;
      sel_q   <= sel_d;
      send_q  <= send_d;
    end
  end

  assign bus.ack_read     = (state_q == ACK);
  assign bus.ops_valid    = (state_q == ENVIO);
  assign bus.op_a         = op_a_q;
  assign bus.op_b         = op_b_q;
  assign bus.valor_actual = valor_q;
  assign bus.digitos      = dig_q;
  assign bus.operando_sel = sel_q;
endmodule

// File: tb/tb_system_captura_operandos.sv
// Directed and randomized key sequences checked against a decimal-entry
// reference model of the operand capture block.
module tb_system_captura_operandos;
  localparam int MAX_DIGITS = 3;
  localparam int DATA_W     = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  captura_operandos_if #(.MAX_DIGITS(MAX_DIGITS), .DATA_W(DATA_W)) bus ();

  system_captura_operandos #(.MAX_DIGITS(MAX_DIGITS), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int ack_total   = 0;
  int ov_total    = 0;

  // Reference model: the operands as a person typing on a calculator sees them.
  int m_a, m_b, m_val, m_dig;
  bit m_sel, m_send;

  always @(negedge clk) begin
    if (bus.ack_read === 1'b1)  ack_total++;
    if (bus.ops_valid === 1'b1) ov_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_val = 0; m_dig = 0; m_sel = 0; m_send = 0;
  endtask

  task automatic model_key(input int n, input bit fr, input bit fg);
    if (fr) model_clear();
    else if (fg) begin
      if (!m_sel) begin m_a = m_val; m_sel = 1; end
      else begin m_b = m_val; m_send = 1; end
      m_val = 0; m_dig = 0;
    end else if (n >= 0 && n <= 9 && m_dig < MAX_DIGITS) begin
      m_val = (m_val * 10 + n) % (1 << DATA_W);
      m_dig++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".op_a"}, 32'(bus.op_a), m_a);
    chk({tag, ".op_b"}, 32'(bus.op_b), m_b);
    chk({tag, ".valor"}, 32'(bus.valor_actual), m_val);
    chk({tag, ".digitos"}, 32'(bus.digitos), m_dig);
    chk({tag, ".sel"}, 32'(bus.operando_sel), 32'(m_sel));
    chk({tag, ".ops_valid"}, 32'(bus.ops_valid), 32'(m_send));
  endtask

  // One full key press: hold, expect a single ack, release, let the pair drain.
  task automatic press(input string tag, input int n, input bit fr, input bit fg, input int hold);
    int acks;
    acks = 0;
    bus.pressed_valid = 1'b1; bus.numero = n; bus.tecla_rst = fr; bus.tecla_guardar = fg;
    for (int i = 0; i < hold + 2; i++) begin
      @(negedge clk);
      if (bus.ack_read === 1'b1) acks++;
    end
    chk({tag, ".acks"}, 32'(acks), 32'd1);
    bus.pressed_valid = 1'b0; bus.tecla_rst = 1'b0; bus.tecla_guardar = 1'b0;
    model_key(n, fr, fg);
    repeat (3) @(negedge clk);
    if (m_send && bus.ops_ready) begin m_sel = 0; m_send = 0; end
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a0, o0, n;
    bit fr, fg;
    rst = 1'b1;
    bus.pressed_valid = 1'b0; bus.numero = 0; bus.tecla_rst = 1'b0;
    bus.tecla_guardar = 1'b0; bus.ops_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset.ack", 32'(bus.ack_read), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 123 / 45 pair with downstream always ready
    a0 = ack_total; o0 = ov_total;
    press("k1", 1, 0, 0, 0);
    press("k2", 2, 0, 0, 3);
    press("k3", 3, 0, 0, 0);
    press("gA", 0, 0, 1, 1);
    press("k4", 4, 0, 0, 0);
    press("k5", 5, 0, 0, 2);
    press("gB", 0, 0, 1, 0);
    chk("pair.op_a", 32'(bus.op_a), 32'd123);
    chk("pair.op_b", 32'(bus.op_b), 32'd45);
    chk("pair.acks", 32'(ack_total - a0), 32'd7);
    chk("pair.ovcycles", 32'(ov_total - o0), 32'd1);

    // fourth digit acknowledged but dropped
    press("k9", 9, 0, 0, 0);
    press("k8", 8, 0, 0, 0);
    press("k7", 7, 0, 0, 0);
    press("k6", 6, 0, 0, 0);
    chk("sat.valor", 32'(bus.valor_actual), 32'd987);
    chk("sat.digitos", 32'(bus.digitos), 32'd3);
    press("gsat", 0, 0, 1, 0);
    chk("sat.op_a", 32'(bus.op_a), 32'd987);
    press("clr0", 0, 1, 0, 0);

    // clear key mid-entry
    o0 = ov_total;
    press("c5", 5, 0, 0, 0);
    press("cg", 0, 0, 1, 0);
    press("c7", 7, 0, 0, 0);
    press("crst", 3, 1, 1, 0);
    chk("clr.op_a", 32'(bus.op_a), 32'd0);
    chk("clr.ovcycles", 32'(ov_total - o0), 32'd0);

    // downstream stall: pending key must wait for the handshake
    bus.ops_ready = 1'b0;
    press("s8", 8, 0, 0, 0);
    press("sg1", 0, 0, 1, 0);
    press("s6", 6, 0, 0, 0);
    press("s1", 1, 0, 0, 0);
    press("sg2", 0, 0, 1, 0);
    a0 = ack_total;
    bus.pressed_valid = 1'b1; bus.numero = 2; bus.tecla_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall.ack", 32'(bus.ack_read), 32'd0);
      chk("stall.ops_valid", 32'(bus.ops_valid), 32'd1);
      chk("stall.op_a", 32'(bus.op_a), 32'd8);
      chk("stall.op_b", 32'(bus.op_b), 32'd61);
    end
    bus.tecla_rst = 1'b0;
    bus.ops_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("stall.acks", 32'(ack_total - a0), 32'd1);
    bus.pressed_valid = 1'b0;
    m_sel = 0; m_send = 0;
    model_key(2, 0, 0);
    repeat (3) @(negedge clk);
    check_state("stall.after");
    press("clr1", 0, 1, 0, 0);

    // non-digit key held for a long time
    press("nd10", 10, 0, 0, 20);
    press("ndneg", -4, 0, 0, 0);

    // reset while a key is held in the release-wait phase
    press("r4", 4, 0, 0, 0);
    press("r2", 2, 0, 0, 0);
    a0 = ack_total;
    bus.pressed_valid = 1'b1; bus.numero = 7;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst.ack", 32'(bus.ack_read), 32'd0);
    check_state("rst.held");
    chk("rst.acks", 32'(ack_total - a0), 32'd1);
    rst = 1'b0;
    a0 = ack_total;
    repeat (4) @(negedge clk);
    chk("rst.resume_acks", 32'(ack_total - a0), 32'd1);
    bus.pressed_valid = 1'b0;
    model_key(7, 0, 0);
    repeat (3) @(negedge clk);
    check_state("rst.resume");

    // randomized key stream
    for (int k = 0; k < 60; k++) begin
      n  = int'($urandom_range(0, 13)) - 1;
      fr = ($urandom_range(0, 15) == 0);
      fg = ($urandom_range(0, 4) == 0);
      press("rnd", n, fr, fg, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/system_captura_operandos.md
SYSTEM_CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

Interface
REQ-001 Parameter MAX_DIGITS, default 3, maximum decimal digits accepted per operand.
REQ-002 Parameter DATA_W, default 10, operand width; SHALL satisfy 2^DATA_W > 10^MAX_DIGITS - 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pressed_valid  input  1  upstream key available; held high until acknowledged.
REQ-006 numero  input  32 (integer)  key value; 0-9 are digits, other values are non-digit.
REQ-007 tecla_rst  input  1  upstream clear-key flag, qualified by pressed_valid.
REQ-008 tecla_guardar  input  1  upstream store-key flag, qualified by pressed_valid.
REQ-009 ack_read  output  1  one-cycle key consume pulse to upstream.
REQ-010 op_a, op_b  output  DATA_W each  captured operands.
REQ-011 ops_valid  output  1  operand pair available to downstream.
REQ-012 ops_ready  input  1  downstream accepts pair when high with ops_valid.
REQ-013 valor_actual  output  DATA_W  operand being typed, for display.
REQ-014 digitos  output  $clog2(MAX_DIGITS+1)  digit count of current operand.
REQ-015 operando_sel  output  1  0 = typing A, 1 = typing B.

Function
REQ-016 States SHALL be CAPTURA (keys accepted), ACK, ESPERA_SOLTAR, ENVIO.
REQ-017 In CAPTURA with pressed_valid=1, the block SHALL act on the key at that edge, enter ACK, and drive ack_read=1 for exactly the following cycle.
REQ-018 From ACK, the block SHALL enter ESPERA_SOLTAR and stay until pressed_valid=0, then return to CAPTURA (one key per pressed_valid high period).
REQ-019 Key priority SHALL be tecla_rst > tecla_guardar > digit > non-digit.
REQ-020 tecla_rst SHALL clear op_a, op_b, valor_actual, digitos, operando_sel to 0.
REQ-021 tecla_guardar with operando_sel=0 SHALL copy valor_actual to op_a, clear valor_actual and digitos, set operando_sel=1.
REQ-022 tecla_guardar with operando_sel=1 SHALL copy valor_actual to op_b, clear valor_actual and digitos, and enter ENVIO after the ACK/ESPERA_SOLTAR sequence completes.
REQ-023 guardar with digitos=0 SHALL store operand value 0.
REQ-024 Digit with digitos<MAX_DIGITS SHALL set valor_actual = valor_actual*10 + numero, digitos+1; computation at DATA_W+4 bits, truncated to DATA_W.
REQ-025 Digit with digitos=MAX_DIGITS SHALL be acknowledged and discarded; no wrap.
REQ-026 Non-digit numero with no flag set SHALL be acknowledged and discarded.
REQ-027 In ENVIO, ops_valid SHALL be 1, and op_a/op_b SHALL be held stable; pressed_valid SHALL NOT be acknowledged (upstream stalls), including tecla_rst.
REQ-028 On ops_valid & ops_ready, the block SHALL clear ops_valid, set operando_sel=0, and return to CAPTURA next cycle; op_a/op_b SHALL retain their values until overwritten.
REQ-029 ops_valid SHALL be 0 in every state except ENVIO.

Reset
REQ-030 rst=1 at any edge, in any state, SHALL force CAPTURA, ack_read=0, ops_valid=0, and op_a, op_b, valor_actual, digitos, operando_sel to 0, overriding all simultaneous inputs.
REQ-031 A key pending while rst is high SHALL NOT be acknowledged; it is handled normally from the first cycle after rst goes low.

Verification
REQ-032 Keys 1,2,3,guardar,4,5,guardar, ops_ready=1 -> op_a=123, op_b=45, ops_valid high 1 cycle, 7 ack_read pulses.
REQ-033 Keys 9,8,7,6,guardar -> op_a=987, 4th digit ack'd and ignored, digitos stays 3.
REQ-034 Keys 5,guardar,7,tecla_rst -> op_a=0, valor_actual=0, operando_sel=0, no ops_valid.
REQ-035 Complete pair with ops_ready=0 for 6 cycles, key 2 pressed meanwhile -> ops_valid held, no ack_read, op_a/op_b stable; after ops_ready=1, key 2 ack'd into new A.
REQ-036 numero=10 with no flags, then pressed_valid held 20 cycles -> exactly one ack_read, valor_actual unchanged.
REQ-037 rst asserted during ESPERA_SOLTAR after digits 4,2 -> all outputs 0, state CAPTURA, no ack for held key until rst low.
